seg_scan_display: RTL and testbench

Downstream stage of the frequency meter. It takes the four latched BCD count digits at the end of each gate window and drives the multiplexed 4-digit common-anode 7-segment display. Features: leading-zero blanking, decimal point, overflow indication and an invalid-BCD dash. It replaces the free-running 1 kHz AN rotation with a reset-controlled, glitch-free scanner on sysclk.

---
 rtl/seg_scan_display.sv | 179 +++++++++++++++++
 tb/tb_seg_scan_display.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// -----------------------------------------------------------------------------
// seg_scan_display
//
// Display stage of the frequency meter. At the end of each gate window the
// upstream counter strobes `load` with four BCD digits plus overflow and
// decimal-point information. This block holds those values and scans them
// onto a multiplexed 4-digit common-anode 7-segment display.
//
// Display features: leading-zero blanking, a decimal point, an all-dash
// overflow indication, and a dash for any non-BCD digit value.
//
// Ports
//   sysclk      in   1   system clock, all logic on the rising edge
//   rst_n       in   1   synchronous reset, active-low
//   load        in   1   one-cycle strobe capturing the four fields below
//   digits_in   in  16   BCD digits, [15:12]=digit3 (MSD) .. [3:0]=digit0
//   overflow    in   1   count exceeded 9999
//   dp_en       in   1   decimal point enable
//   dp_sel      in   2   digit index that carries the decimal point
//   cathodes    out  8   segments, active-low, bit0=a .. bit6=g, bit7=dp
//   AN          out  4   digit anodes, active-low, one-hot-low, AN[0]=digit0
//   frame_done  out  1   one-cycle pulse on the tick that selects digit3
//
// Load handshake: `load` is a fire-and-forget strobe with no ready. Whenever
// load=1 at a rising edge (and rst_n=1) the four fields are captured into the
// holding registers. The captured values reach the display on the next
// scan tick. A tick in the same cycle as the load still shows the old values.
//
// Scanning: a prescaler divides sysclk by SCAN_DIV. On each tick the slot
// index advances and AN/cathodes are reloaded together from registers, so
// the pins only change on tick edges and never glitch within a slot.
// SCAN_DIV must be at least 2.
// -----------------------------------------------------------------------------
module seg_scan_display #(
  parameter int unsigned SCAN_DIV = 100000,
  parameter int unsigned BLANK_LZ = 1
) (
  input  logic        sysclk,
  input  logic        rst_n,
  input  logic        load,
  input  logic [15:0] digits_in,
  input  logic        overflow,
  input  logic        dp_en,
  input  logic [1:0]  dp_sel,
  output logic [7:0]  cathodes,
  output logic [3:0]  AN,
  output logic        frame_done
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(SCAN_DIV - 1);

  // Segment patterns, active-low, dp bit (bit7) off.
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [7:0] SEG_DASH  = 8'hBF;

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0] cnt;
  logic [1:0]    sel;
  logic [15:0]   hold_digits;
  logic          hold_ov;
  logic          hold_dp_en;
  logic [1:0]    hold_dp_sel;

  // ---------------------------------------------------------------------------
  // Next-slot values, computed from the current holding registers
  // ---------------------------------------------------------------------------
  logic       tick;
  logic [1:0] next_sel;
  logic [3:0] next_digit;
  logic [3:0] zero_run;
  logic       dp_protect;
  logic       blank;
  logic [7:0] seg_next;
  logic [3:0] an_next;

  function automatic logic [7:0] bcd_to_seg(input logic [3:0] d);
    logic [7:0] s;
    case (d)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = SEG_DASH;  // 10..15 are not BCD
    endcase
    return s;
  endfunction

  assign tick     = (cnt == CNT_LAST);
  assign next_sel = sel + 2'd1;

  always_comb begin
    next_digit = 4'd0;
    case (next_sel)
      2'd0:    next_digit = hold_digits[3:0];
      2'd1:    next_digit = hold_digits[7:4];
      2'd2:    next_digit = hold_digits[11:8];
      default: next_digit = hold_digits[15:12];
    endcase
  end

  // zero_run[k] is set when digit k and every digit above it are zero.
  // Digit0 is excluded so a reading of zero still shows one "0".
  always_comb begin
    zero_run    = 4'b0000;
    zero_run[3] = (hold_digits[15:12] == 4'd0);
    zero_run[2] = zero_run[3] && (hold_digits[11:8] == 4'd0);
    zero_run[1] = zero_run[2] && (hold_digits[7:4] == 4'd0);
    zero_run[0] = 1'b0;
  end

  // Digits at or right of the decimal point are significant (e.g. "0.05").
  assign dp_protect = hold_dp_en && (next_sel <= hold_dp_sel);

  assign blank = (BLANK_LZ != 0) && !hold_ov && zero_run[next_sel] && !dp_protect;

  always_comb begin
    seg_next = SEG_BLANK;
    if (hold_ov) begin
      seg_next = SEG_DASH;
    end else if (blank) begin
      seg_next = SEG_BLANK;
    end else begin
      seg_next = bcd_to_seg(next_digit);
      if (hold_dp_en && (next_sel == hold_dp_sel)) begin
        seg_next[7] = 1'b0;
      end
    end
  end

  assign an_next = ~(4'b0001 << next_sel);

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge sysclk) begin
    if (!rst_n) begin
      cnt         <= '0;
      sel         <= 2'd3;  // first tick advances to digit0
      hold_digits <= 16'h0000;
      hold_ov     <= 1'b0;
      hold_dp_en  <= 1'b0;
      hold_dp_sel <= 2'd0;
      AN          <= 4'b1111;
      cathodes    <= SEG_BLANK;
      frame_done  <= 1'b0;
    end else begin
      if (tick) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + CW'(1);
      end

      if (load) begin
        hold_digits <= digits_in;
        hold_ov     <= overflow;
        hold_dp_en  <= dp_en;
        hold_dp_sel <= dp_sel;
      end

      frame_done <= 1'b0;
      if (tick) begin
        sel        <= next_sel;
        AN         <= an_next;
        cathodes   <= seg_next;
        frame_done <= (next_sel == 2'd3);
      end
    end
  end

endmodule

// File: tb/tb_seg_scan_display.sv
// -----------------------------------------------------------------------------
// tb_seg_scan_display
//
// Directed bench for seg_scan_display with SCAN_DIV=4, BLANK_LZ=1.
// Inputs are driven 1 ns after a rising edge; outputs are sampled at the same
// point, so each sample reflects the edge just taken. `ph` tracks the bench's
// own view of the prescaler phase so each scan tick can be hit exactly.
// Expected {AN, cathodes} per slot are hand-computed and queued in exp_q;
// frame_done is expected high exactly on the slot whose AN is 0111.
// -----------------------------------------------------------------------------
module tb_seg_scan_display;

  localparam int DIV = 4;

  // clock / reset
  logic        sysclk = 1'b0;
  logic        rst_n;
  logic        load;
  logic [15:0] digits_in;
  logic        overflow;
  logic        dp_en;
  logic [1:0]  dp_sel;
  logic [7:0]  cathodes;
  logic [3:0]  AN;
  logic        frame_done;

  always #5 sysclk = ~sysclk;

  seg_scan_display #(.SCAN_DIV(DIV), .BLANK_LZ(1)) dut (
    .sysclk     (sysclk),
    .rst_n      (rst_n),
    .load       (load),
    .digits_in  (digits_in),
    .overflow   (overflow),
    .dp_en      (dp_en),
    .dp_sel     (dp_sel),
    .cathodes   (cathodes),
    .AN         (AN),
    .frame_done (frame_done)
  );

  // scoreboard
  logic [11:0] exp_q[$];
  logic [11:0] cur;     // {AN, cathodes} expected for the slot currently shown
  int          total = 0;
  int          bad   = 0;
  int          ph    = 0;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // driver tasks
  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) begin
      logic r;
      r = rst_n;
      @(posedge sysclk);
      #1;
      if (!r) ph = 0;
      else    ph = (ph == DIV - 1) ? 0 : ph + 1;
    end
  endtask

  task automatic do_load(input logic [15:0] d, input logic o, input logic e, input logic [1:0] s);
    digits_in = d;
    overflow  = o;
    dp_en     = e;
    dp_sel    = s;
    load      = 1'b1;
    cyc(1);
    load      = 1'b0;
  endtask

  task automatic push(input logic [3:0] an, input logic [7:0] cat);
    exp_q.push_back({an, cat});
  endtask

  // Compare the outputs just produced by a tick edge with the next queued slot.
  task automatic check_slot_now(input string tag);
    logic [11:0] e;
    if (exp_q.size() == 0) begin
      total++;
      bad++;
      $error("FAIL %s_queue observed=empty expected=entry", tag);
    end else begin
      e = exp_q.pop_front();
      cur = e;
      check({tag, "_an"},  {4'h0, AN}, {4'h0, e[11:8]});
      check({tag, "_cat"}, cathodes, e[7:0]);
      check({tag, "_fd"},  {7'h0, frame_done}, {7'h0, (e[11:8] == 4'b0111)});
    end
  endtask

  // Run to the next tick; one cycle before it, confirm the slot held steady
  // and frame_done has dropped.
  task automatic next_slot(input string tag);
    int n;
    n = DIV - ph;
    if (n > 1) begin
      cyc(n - 1);
      check({tag, "_hold_an"},  {4'h0, AN}, {4'h0, cur[11:8]});
      check({tag, "_hold_cat"}, cathodes, cur[7:0]);
      check({tag, "_hold_fd"},  {7'h0, frame_done}, 8'h00);
    end
    cyc(1);
    check_slot_now(tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n     = 1'b0;
    load      = 1'b0;
    digits_in = 16'h0000;
    overflow  = 1'b0;
    dp_en     = 1'b0;
    dp_sel    = 2'd0;
    cur       = {4'hF, 8'hFF};

    // 1. reset held for 3 cycles, then first slot 4 cycles after release
    cyc(3);
    check("rst_an",  {4'h0, AN}, 8'h0F);
    check("rst_cat", cathodes, 8'hFF);
    check("rst_fd",  {7'h0, frame_done}, 8'h00);
    rst_n = 1'b1;
    push(4'b1110, 8'hC0);
    next_slot("first");

    // 2. normal scan of 1234, starting from digit1
    do_load(16'h1234, 1'b0, 1'b0, 2'd0);
    push(4'b1101, 8'hB0);
    push(4'b1011, 8'hA4);
    push(4'b0111, 8'hF9);
    push(4'b1110, 8'h99);
    for (int i = 0; i < 4; i++) next_slot("scan1234");

    // 3A. leading-zero blanking
    do_load(16'h0007, 1'b0, 1'b0, 2'd0);
    push(4'b1101, 8'hFF);
    push(4'b1011, 8'hFF);
    push(4'b0111, 8'hFF);
    push(4'b1110, 8'hF8);
    for (int i = 0; i < 4; i++) next_slot("lz0007");

    // 3B. decimal point on digit2 keeps digits 1..2 visible
    do_load(16'h0005, 1'b0, 1'b1, 2'd2);
    push(4'b1101, 8'hC0);
    push(4'b1011, 8'h40);
    push(4'b0111, 8'hFF);
    push(4'b1110, 8'h92);
    for (int i = 0; i < 4; i++) next_slot("dp0005");

    // 4A. overflow: all dashes, dp suppressed even with dp_en set
    do_load(16'h9999, 1'b1, 1'b1, 2'd1);
    push(4'b1101, 8'hBF);
    push(4'b1011, 8'hBF);
    push(4'b0111, 8'hBF);
    push(4'b1110, 8'hBF);
    for (int i = 0; i < 4; i++) next_slot("ovf");

    // 4B. invalid BCD digit shows a dash
    do_load(16'h00A0, 1'b0, 1'b0, 2'd0);
    push(4'b1101, 8'hBF);
    push(4'b1011, 8'hFF);
    push(4'b0111, 8'hFF);
    push(4'b1110, 8'hC0);
    for (int i = 0; i < 4; i++) next_slot("badbcd");

    // 5A. load mid-slot: nothing changes until the next tick
    cyc(1);
    check("mid_before_cat", cathodes, 8'hC0);
    do_load(16'h8888, 1'b0, 1'b0, 2'd0);
    check("mid_after_cat", cathodes, 8'hC0);
    check("mid_after_an", {4'h0, AN}, 8'h0E);
    push(4'b1101, 8'h80);
    next_slot("mid_new");

    // 5B. load on the tick edge: that slot shows old data, next shows new
    cyc(DIV - 1);
    push(4'b1011, 8'h80);
    do_load(16'h4321, 1'b0, 1'b0, 2'd0);
    check_slot_now("coinc_old");
    push(4'b0111, 8'h99);
    push(4'b1110, 8'hF9);
    push(4'b1101, 8'hA4);
    push(4'b1011, 8'hB0);
    for (int i = 0; i < 4; i++) next_slot("coinc_new");

    // 6. reset while AN=1011, with a load attempted during reset
    cyc(1);
    rst_n     = 1'b0;
    load      = 1'b1;
    digits_in = 16'h9999;
    cyc(1);
    check("midrst_an",  {4'h0, AN}, 8'h0F);
    check("midrst_cat", cathodes, 8'hFF);
    check("midrst_fd",  {7'h0, frame_done}, 8'h00);
    load      = 1'b0;
    digits_in = 16'h0000;
    cyc(1);
    rst_n = 1'b1;
    cur   = {4'hF, 8'hFF};
    push(4'b1110, 8'hC0);
    push(4'b1101, 8'hFF);
    push(4'b1011, 8'hFF);
    push(4'b0111, 8'hFF);
    for (int i = 0; i < 4; i++) next_slot("after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
